// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands plus carry-in, CHUNK bits per clock,
// with a registered inter-chunk carry and a start/busy/done handshake.
module chunked_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CHUNK:0]   chunk_add;

    // Operand regs shift right one chunk per RUN cycle, so the active chunk always sits at bit 0.
    assign chunk_add = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = chunk_add[CHUNK];
                // Result chunks enter at the top and move down, so the last one lands at the MSBs.
                work_d  = (work_q >> CHUNK)
                        | (WIDTH'(chunk_add[CHUNK-1:0]) << (WIDTH - CHUNK));
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = work_d;
                    cout_d  = chunk_add[CHUNK];
                    ovf_d   = (a_q[CHUNK-1] == b_q[CHUNK-1])
                            && (chunk_add[CHUNK-1] != a_q[CHUNK-1]);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    work_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: three instances (CHUNK=4, 1, 16) share one stimulus stream
// and are checked every cycle against a latency-plus-arithmetic model, plus literal results.
module tb_chunked_serial_adder;
    localparam int NL [3] = '{4, 16, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;

    logic [2:0]  busy_w, done_w, cout_w, ovf_w;
    logic [15:0] sum_w [3];

    int n_pass = 0;
    int n_total = 0;
    int lat [3];
    int ndone [3];

    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .cout(cout_w[0]),
        .overflow(ovf_w[0])
    );
    chunked_serial_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .cout(cout_w[1]),
        .overflow(ovf_w[1])
    );
    chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .cout(cout_w[2]),
        .overflow(ovf_w[2])
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[dut%0d] @%0t: got %h, expected %h", name, idx, $time, act, exp);
    endtask

    // Model: an accepted op reports a+b+cin exactly NL cycles later; signed overflow means
    // the true signed sum falls outside the 16-bit two's-complement range.
    logic        m_busy [3] = '{3{1'b0}};
    logic        m_done [3] = '{3{1'b0}};
    int          m_left [3] = '{3{0}};
    logic [15:0] m_a [3] = '{3{16'h0}};
    logic [15:0] m_b [3] = '{3{16'h0}};
    logic        m_c [3] = '{3{1'b0}};
    logic [16:0] m_full [3] = '{3{17'h0}};
    logic        m_ovf [3] = '{3{1'b0}};

    function automatic logic signed_ovf(input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + (c ? 1 : 0);
        return (s > 32767) || (s < -32768);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_left[i] <= 0;
                m_full[i] <= '0;
                m_ovf[i]  <= 1'b0;
            end else begin
                m_done[i] <= 1'b0;
                if (m_busy[i]) begin
                    if (m_left[i] == 1) begin
                        m_busy[i] <= 1'b0;
                        m_done[i] <= 1'b1;
                        m_full[i] <= {1'b0, m_a[i]} + {1'b0, m_b[i]} + {16'h0, m_c[i]};
                        m_ovf[i]  <= signed_ovf(m_a[i], m_b[i], m_c[i]);
                    end else begin
                        m_left[i] <= m_left[i] - 1;
                    end
                end else if (start) begin
                    m_busy[i] <= 1'b1;
                    m_left[i] <= NL[i];
                    m_a[i]    <= a;
                    m_b[i]    <= b;
                    m_c[i]    <= cin;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk("busy", i, 32'(busy_w[i]), 32'(m_busy[i]));
            chk("done", i, 32'(done_w[i]), 32'(m_done[i]));
            chk("sum", i, 32'(sum_w[i]), 32'(m_full[i][15:0]));
            chk("cout", i, 32'(cout_w[i]), 32'(m_full[i][16]));
            chk("overflow", i, 32'(ovf_w[i]), 32'(m_ovf[i]));
        end
    end

    // Launch one op, optionally pulse start with all-ones operands for `pulse` cycles during
    // RUN, scramble inputs otherwise, and wait (bounded) until every instance is idle.
    task automatic do_op(input logic [15:0] oa, input logic [15:0] ob, input logic oc,
                         input int pulse);
        int cyc;
        @(negedge clk);
        start = 1'b1; a = oa; b = ob; cin = oc;
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0;
            ndone[i] = 0;
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (done_w[i]) begin
                    ndone[i]++;
                    if (lat[i] == 0) lat[i] = cyc;
                end
            end
            if (cyc <= pulse) begin
                start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
            end else begin
                start = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            end
        end while (!(cyc > pulse && busy_w == 3'b000 && done_w == 3'b000) && cyc < 40);
        chk("op_finished", 0, 32'({busy_w, done_w}), 32'h0);
    endtask

    task automatic chk_result(input int i, input logic [15:0] es, input logic ec,
                              input logic eo);
        chk("lit_sum", i, 32'(sum_w[i]), 32'(es));
        chk("lit_cout", i, 32'(cout_w[i]), 32'(ec));
        chk("lit_ovf", i, 32'(ovf_w[i]), 32'(eo));
    endtask

    task automatic chk_all_zero();
        chk("rst_busy", 0, 32'(busy_w), 32'h0);
        chk("rst_done", 0, 32'(done_w), 32'h0);
        for (int i = 0; i < 3; i++) chk_result(i, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset with toggling inputs: start must be ignored.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = k[0]; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            #1 chk_all_zero();
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        // Basic add and latency per chunking.
        do_op(16'h0003, 16'h0001, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            chk_result(i, 16'h0004, 1'b0, 1'b0);
            chk("latency", i, 32'(lat[i]), 32'(NL[i] + 1));
            chk("done_pulses", i, 32'(ndone[i]), 32'd1);
        end

        // Full carry ripple, then signed overflow.
        do_op(16'hFFFF, 16'h0000, 1'b1, 0);
        for (int i = 0; i < 3; i++) chk_result(i, 16'h0000, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 0);
        for (int i = 0; i < 3; i++) chk_result(i, 16'h8000, 1'b0, 1'b1);

        // Start pulsed during RUN must be ignored (CHUNK=16 finishes first and may accept it).
        do_op(16'h1234, 16'h1111, 1'b0, 2);
        for (int i = 0; i < 2; i++) begin
            chk_result(i, 16'h2345, 1'b0, 1'b0);
            chk("busy_run_pulses", i, 32'(ndone[i]), 32'd1);
        end

        // Back-to-back start in the DONE cycle of the CHUNK=4 instance.
        @(negedge clk);
        start = 1'b1; a = 16'h1000; b = 16'h0001; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && !done_w[0]; k++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom);
        end
        chk("b2b_first_done", 0, 32'(done_w[0]), 32'd1);
        chk_result(0, 16'h1001, 1'b0, 1'b0);
        start = 1'b1; a = 16'h8000; b = 16'h8000; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 0, 32'(busy_w[0]), 32'd1);
        chk("b2b_hold", 0, 32'(sum_w[0]), 32'h1001);
        for (int k = 0; k < 40 && (busy_w != 3'b000 || done_w != 3'b000); k++) @(negedge clk);
        chk("b2b_finished", 0, 32'({busy_w, done_w}), 32'h0);
        chk_result(0, 16'h0000, 1'b1, 1'b1);

        // Reset in the second RUN cycle clears everything at once.
        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h0001; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero();
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h00FF, 16'h0001, 1'b0, 0);
        for (int i = 0; i < 3; i++) chk_result(i, 16'h0100, 1'b0, 1'b0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
